// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router constants, flit encodings and injector state type
package noc_pkg;

   localparam int LEN_W = 12;

   localparam logic [2:0] FLIT_IDLE = 3'b000;
   localparam logic [2:0] FLIT_HEAD = 3'b001;
   localparam logic [2:0] FLIT_BODY = 3'b010;
   localparam logic [2:0] FLIT_TAIL = 3'b100;

   localparam int L = 0;
   localparam int N = 1;
   localparam int E = 2;
   localparam int W = 3;
   localparam int S = 4;

   typedef enum logic [1:0] {IDLE, REQ, SEND, HOLD} src_state_t;

endpackage

// File: rtl/flit_source.sv
// rtl/flit_source.sv - per-port packet injector driving the router arbiter request bundle
module flit_source #(
   parameter int DATA_W = 32,
   parameter int SLACK  = 4,
   parameter int LEN_W  = noc_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_valid,
   output logic              pkt_ready,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [DATA_W-1:0] din,
   input  logic              grant,
   output logic              req,
   output logic [2:0]        flit_id,
   output logic [LEN_W-1:0]  length,
   output logic              flit_valid,
   output logic [DATA_W-1:0] flit_data
);
   import noc_pkg::src_state_t;
   import noc_pkg::IDLE;
   import noc_pkg::REQ;
   import noc_pkg::SEND;
   import noc_pkg::HOLD;
   import noc_pkg::FLIT_IDLE;
   import noc_pkg::FLIT_HEAD;
   import noc_pkg::FLIT_BODY;
   import noc_pkg::FLIT_TAIL;

   src_state_t        state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  rem;
   logic [LEN_W-1:0]  len_clamp;
   logic [LEN_W:0]    budget;
   logic              active;
   logic              last;

   function automatic logic [2:0] flit_kind(input logic [LEN_W-1:0] r,
                                            input logic [LEN_W-1:0] l);
      if (r == l)
         return FLIT_HEAD;
      else if (r == LEN_W'(1))
         return FLIT_TAIL;
      else
         return FLIT_BODY;
   endfunction

   // A grant seen while still in REQ or HOLD is used in the same cycle.
   assign active     = grant && (state != IDLE);
   assign last       = (rem == LEN_W'(1));
   assign din_ready  = active;
   assign flit_valid = active && din_valid;
   assign flit_data  = flit_valid ? din : '0;

   assign len_clamp = (pkt_len < LEN_W'(2)) ? LEN_W'(2) : pkt_len;
   assign budget    = {1'b0, len_clamp} + (LEN_W+1)'(SLACK);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len_q     <= '0;
         rem       <= '0;
         req       <= 1'b0;
         flit_id   <= FLIT_IDLE;
         length    <= '0;
         pkt_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pkt_ready <= 1'b1;
               if (pkt_valid && pkt_ready) begin
                  len_q     <= len_clamp;
                  rem       <= len_clamp;
                  req       <= 1'b1;
                  flit_id   <= FLIT_HEAD;
                  length    <= budget[LEN_W] ? '1 : budget[LEN_W-1:0];
                  pkt_ready <= 1'b0;
                  state     <= REQ;
               end
            end
            default: begin
               if (flit_valid) begin
                  if (last) begin
                     rem       <= '0;
                     req       <= 1'b0;
                     flit_id   <= FLIT_IDLE;
                     length    <= '0;
                     pkt_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     rem     <= rem - LEN_W'(1);
                     flit_id <= flit_kind(rem - LEN_W'(1), len_q);
                     state   <= SEND;
                  end
               end else if (active) begin
                  state <= SEND;
               end else if (state == SEND) begin
                  state <= HOLD;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flit_source.sv
// tb/tb_flit_source.sv - randomized scoreboard bench for flit_source
module tb_flit_source;
   localparam int DATA_W = 32;
   localparam int SLACK  = 4;
   localparam int LEN_W  = 12;
   localparam logic [2:0] F_IDLE = 3'b000;
   localparam logic [2:0] F_HEAD = 3'b001;
   localparam logic [2:0] F_BODY = 3'b010;
   localparam logic [2:0] F_TAIL = 3'b100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pkt_valid;
   logic              pkt_ready;
   logic [LEN_W-1:0]  pkt_len;
   logic              din_valid;
   logic              din_ready;
   logic [DATA_W-1:0] din;
   logic              grant;
   logic              req;
   logic [2:0]        flit_id;
   logic [LEN_W-1:0]  length;
   logic              flit_valid;
   logic [DATA_W-1:0] flit_data;

   typedef struct {logic [2:0] id; logic [DATA_W-1:0] data;} flit_t;
   typedef struct {logic [DATA_W-1:0] data; bit last;} word_t;
   typedef struct {logic [LEN_W-1:0] len; logic [LEN_W-1:0] budget;} desc_t;

   flit_t exp_q[$];
   word_t word_q[$];
   desc_t desc_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0, acc_cyc = 0, fall_cyc = 0, last_gap = 0, low_run = 0;
   int nflits = 0, sent = 0, din_pct = 100;
   int pre_at = 0, pre_len = 0, hold_cnt = 0;
   int stall_at = 0, stall_len = 0, stall_cnt = 0;
   bit in_hold = 0, in_stall = 0, just_acc = 0, after_tail = 0;
   bit req_seen = 0, seen_hi = 0, fire_pkt = 0, fire_din = 0;
   logic [LEN_W-1:0] cur_budget = '0;

   flit_source #(.DATA_W(DATA_W), .SLACK(SLACK), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
      .din_valid(din_valid), .din_ready(din_ready), .din(din),
      .grant(grant), .req(req), .flit_id(flit_id), .length(length),
      .flit_valid(flit_valid), .flit_data(flit_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: a packet is max(len,2) payload words, typed head/body.../tail.
   task automatic issue(input int len);
      int lq, b;
      desc_t d;
      word_t w;
      flit_t f;
      lq = (len < 2) ? 2 : len;
      b = lq + SLACK;
      if (b > (1 << LEN_W) - 1) b = (1 << LEN_W) - 1;
      d.len = LEN_W'(len);
      d.budget = LEN_W'(b);
      desc_q.push_back(d);
      for (int i = 0; i < lq; i++) begin
         w.data = $urandom;
         w.last = (i == lq - 1);
         word_q.push_back(w);
         f.id = (i == 0) ? F_HEAD : ((i == lq - 1) ? F_TAIL : F_BODY);
         f.data = w.data;
         exp_q.push_back(f);
      end
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(desc_q.size() == 0 && exp_q.size() == 0 && req == 1'b0) && n < bound);
      if (n >= bound) begin
         checks++;
         errors++;
         $display("FAIL timeout_done waited=%0d limit=%0d", n, bound);
      end
      #1;
   endtask

   task automatic wait_ready(input int bound);
      int n = 0;
      while (pkt_ready !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (n >= bound) begin
         checks++;
         errors++;
         $display("FAIL timeout_ready waited=%0d limit=%0d", n, bound);
      end
   endtask

   // Upstream source, payload stream and arbiter model (grant registered from req).
   initial begin
      word_t w;
      pkt_valid = 0; pkt_len = '0; din_valid = 0; din = '0; grant = 0;
      forever begin
         @(negedge clk);
         fire_pkt = pkt_valid && pkt_ready && !rst;
         fire_din = din_valid && din_ready && !rst;
         if (req) begin
            if (seen_hi && low_run > 0) last_gap = low_run;
            low_run = 0;
            seen_hi = 1;
         end else begin
            if (req_seen) fall_cyc = cyc;
            if (seen_hi) low_run++;
         end
         if (!rst && just_acc) begin
            chk("hdr_req", req, 1);
            chk("hdr_id", flit_id, F_HEAD);
            chk("hdr_length", length, cur_budget);
            just_acc = 0;
         end
         if (!rst && after_tail) begin
            chk("post_tail_req", req, 0);
            chk("post_tail_id", flit_id, F_IDLE);
            chk("post_tail_length", length, 0);
            after_tail = 0;
         end
         if (!rst && in_hold && exp_q.size() > 0) begin
            chk("hold_req", req, 1);
            chk("hold_id", flit_id, exp_q[0].id);
            chk("hold_flit_valid", flit_valid, 0);
            chk("hold_din_ready", din_ready, 0);
         end
         if (!rst && in_stall) begin
            chk("stall_req", req, 1);
            chk("stall_flit_valid", flit_valid, 0);
         end
         req_seen = req;
         @(posedge clk);
         cyc++;
         #1;
         if (rst) begin
            desc_q.delete(); word_q.delete(); exp_q.delete();
            sent = 0; hold_cnt = 0; stall_cnt = 0; pre_at = 0; stall_at = 0;
            just_acc = 0; after_tail = 0; seen_hi = 0; low_run = 0;
         end else begin
            if (fire_pkt && desc_q.size() > 0) begin
               cur_budget = desc_q[0].budget;
               void'(desc_q.pop_front());
               acc_cyc = cyc;
               just_acc = 1;
            end
            if (fire_din && word_q.size() > 0) begin
               w = word_q.pop_front();
               if (w.last) begin
                  sent = 0;
                  after_tail = 1;
               end else begin
                  sent++;
               end
            end
            if (pre_at > 0 && sent == pre_at) begin hold_cnt = pre_len; pre_at = 0; end
            if (stall_at > 0 && sent == stall_at) begin stall_cnt = stall_len; stall_at = 0; end
         end
         in_hold = (hold_cnt > 0);
         if (in_hold) hold_cnt--;
         in_stall = (stall_cnt > 0);
         if (in_stall) stall_cnt--;
         grant = req_seen && !in_hold;
         pkt_valid = (desc_q.size() > 0);
         pkt_len = pkt_valid ? desc_q[0].len : LEN_W'($urandom);
         din_valid = (word_q.size() > 0) && !in_stall && ($urandom_range(0, 99) < din_pct);
         din = din_valid ? word_q[0].data : $urandom;
      end
   end

   // Scoreboard monitor.
   initial begin
      flit_t f;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("din_ready_rule", din_ready, grant && req);
            if (flit_valid) begin
               chk("flit_while_req", req, 1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_flit actual_id=%0h actual_data=%0h expected=none", flit_id, flit_data);
               end else begin
                  f = exp_q.pop_front();
                  chk("flit_id", flit_id, f.id);
                  chk("flit_data", flit_data, f.data);
                  nflits++;
               end
            end
         end
      end
   end

   initial begin
      int n0, len, lq;
      repeat (3) @(negedge clk);
      chk("rst_req", req, 0);
      chk("rst_flit_id", flit_id, F_IDLE);
      chk("rst_length", length, 0);
      chk("rst_flit_valid", flit_valid, 0);
      chk("rst_flit_data", flit_data, 0);
      chk("rst_pkt_ready", pkt_ready, 0);
      chk("rst_din_ready", din_ready, 0);
      rst = 0;
      wait_ready(20);

      n0 = nflits; issue(4); wait_done(200);
      chk("len4_cycles", fall_cyc - acc_cyc, 5);
      chk("len4_flits", nflits - n0, 4);

      n0 = nflits; issue(1); wait_done(200);
      chk("len1_cycles", fall_cyc - acc_cyc, 3);
      chk("len1_flits", nflits - n0, 2);

      stall_at = 1; stall_len = 3;
      n0 = nflits; issue(4); wait_done(200);
      chk("stall_cycles", fall_cyc - acc_cyc, 8);
      chk("stall_flits", nflits - n0, 4);

      pre_at = 2; pre_len = 5;
      n0 = nflits; issue(6); wait_done(200);
      chk("preempt_cycles", fall_cyc - acc_cyc, 12);
      chk("preempt_flits", nflits - n0, 6);

      last_gap = 0;
      n0 = nflits; issue(3); issue(2); wait_done(200);
      chk("b2b_gap", last_gap, 1);
      chk("b2b_cycles", fall_cyc - acc_cyc, 3);
      chk("b2b_flits", nflits - n0, 5);

      stall_at = 3; stall_len = 1000;
      issue(6);
      n0 = 0;
      do begin @(negedge clk); n0++; end while (!(in_stall && sent == 3) && n0 < 100);
      if (n0 >= 100) begin
         checks++; errors++;
         $display("FAIL timeout_midbody waited=%0d limit=100", n0);
      end
      rst = 1;
      @(negedge clk);
      chk("abort_req", req, 0);
      chk("abort_flit_id", flit_id, F_IDLE);
      chk("abort_length", length, 0);
      chk("abort_flit_valid", flit_valid, 0);
      chk("abort_flit_data", flit_data, 0);
      chk("abort_pkt_ready", pkt_ready, 0);
      chk("abort_din_ready", din_ready, 0);
      rst = 0;
      wait_ready(20);
      n0 = nflits; issue(3); wait_done(200);
      chk("after_abort_flits", nflits - n0, 3);

      for (int p = 0; p < 14; p++) begin
         len = $urandom_range(0, 10);
         lq = (len < 2) ? 2 : len;
         din_pct = $urandom_range(40, 100);
         if ($urandom_range(0, 1) == 1) begin
            pre_at = $urandom_range(1, lq - 1);
            pre_len = $urandom_range(1, 4);
         end
         if ($urandom_range(0, 2) == 0) begin
            stall_at = $urandom_range(1, lq - 1);
            stall_len = $urandom_range(1, 3);
         end
         n0 = nflits; issue(len); wait_done(600);
         chk("rand_flits", nflits - n0, lq);
         pre_at = 0; stall_at = 0;
      end

      din_pct = 100;
      n0 = nflits; issue(4091); wait_done(5000);
      chk("long_exact_flits", nflits - n0, 4091);
      n0 = nflits; issue(4093); wait_done(5000);
      chk("long_sat_flits", nflits - n0, 4093);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flit_source.md
Name: flit_source

Overview:
- Per-port packet injector; sits on the requester side of the 5-port router arbiter (L/N/E/W/S).
- Takes a packet descriptor plus a payload word stream and drives the arbiter-facing request bundle: req, flit_id, length.
- Emits header/body/tail flits only while granted.
- Survives timeout preemption: holds position and resumes on regrant.
- One instance per input port.

Parameters:
- DATA_W, 32, payload/flit data width.
- SLACK, 4, extra clock periods added to the flit count to form the timeout budget.
- LEN_W, 12, width of packet length and timeout length.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pkt_valid  in  1  descriptor valid
- pkt_ready  out  1  descriptor accepted when valid&ready
- pkt_len  in  LEN_W  packet length in flits, header and tail included
- din_valid  in  1  payload word valid
- din_ready  out  1  payload word consumed when valid&ready
- din  in  DATA_W  payload word
- grant  in  1  this port's bit of the arbiter's registered one-hot state
- req  out  1  request to arbiter
- flit_id  out  3  flit type: 000 idle, 001 header, 010 body, 100 tail
- length  out  LEN_W  timeout budget presented with the header
- flit_valid  out  1  flit on flit_data this cycle
- flit_data  out  DATA_W  flit payload

Behaviour:
- Reset values: req=0, flit_id=000, length=0, flit_valid=0, flit_data=0, pkt_ready=0, din_ready=0; FSM=IDLE; rem=0.
- rst mid-packet aborts immediately. No tail is sent. Unconsumed payload stays upstream.
- FSM states: IDLE, REQ, SEND, HOLD.
- IDLE:
  - pkt_ready=1.
  - On pkt_valid: len_q = max(pkt_len,2); rem = len_q; go to REQ.
  - On the same edge, register req=1, flit_id=001, length = len_q+SLACK. Saturate at 2^LEN_W-1; no wrap.
- REQ:
  - Hold req=1 and flit_id=001, so the arbiter timer loads length while header is present.
  - When grant=1, go to SEND in the same cycle's evaluation.
- SEND (grant=1):
  - din_ready = grant.
  - When din_valid&grant: flit_valid=1, flit_data=din, flit_id = type of the current flit, rem decrements.
  - Flit type: rem==len_q → 001; rem==1 → 100; else 010.
  - din_valid=0 while granted: bubble (flit_valid=0), no state change; the arbiter timer keeps running.
  - Tail transfer (rem==1 consumed): next cycle req=0, flit_id=000, length=0, state IDLE.
- Preemption: grant falls in SEND with rem>0 → HOLD.
- HOLD:
  - req stays 1; flit_id shows the next flit's type; no flit_valid, din_ready=0.
  - On grant=1 → SEND and resume from rem.
  - Header is not resent. length is unchanged, since the arbiter reloads only on 001.
- Latency, per packet:
  - Descriptor accept at edge N.
  - req visible cycle N+1; arbiter registers grant at edge N+2.
  - First flit in cycle N+2 at earliest.
- Back-to-back packets:
  - Tail cycle T → IDLE at T+1; new descriptor accepted at T+1.
  - req is low for at least one cycle (T+1) so the arbiter may rotate.
- grant=1 while in IDLE: ignored; nothing is output.
- din_ready is never asserted outside SEND&grant.
- Flit data is combinational from din when transferred: flit_data=din, flit_valid=din_valid&grant&SEND; all other outputs are registered.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_IDLE=3'b000, FLIT_HEAD=3'b001, FLIT_BODY=3'b010, FLIT_TAIL=3'b100
  - port index constants L,N,E,W,S
  - FSM state typedef
  - LEN_W
- No sub-module; the flit counter/type decode is inline.
- The top level instantiates five flit_source alongside the arbiter.

Test Plan:
- pkt_len=4, SLACK=4, din always valid, grant tied from an arbiter model:
  - descriptor accepted edge 0; req=1, flit_id=001, length=8 in cycle 1.
  - Flits 001,010,010,100 in cycles 2-5; req=0 in cycle 6.
- pkt_len=1 → clamped to 2: length=6; flits 001 then 100.
- Payload stall: din_valid low for 3 cycles after header → 3 bubble cycles with flit_valid=0 and req=1; body resumes, total flit count 4.
- Preemption: grant dropped after 2 of 6 flits for 5 cycles:
  - During the hold: req=1, flit_id=010, no flit_valid, din_ready=0.
  - On regrant the remaining 4 flits follow, ending in 100; no duplicate header.
- Back-to-back descriptors (len 3 then 2): req low exactly one cycle between packets; second header length=6.
- rst asserted mid-body (rem=3): next cycle all outputs at reset values, FSM IDLE; a new packet after reset starts with header 001.
